// File: rtl/param_readback_pkg.sv
// Shared wave-generator definitions: parameter-bus geometry and the
// readback state encoding used by the parameter-packing logic.
package param_readback_pkg;

    localparam int DEF_WORD_W    = 16;
    localparam int DEF_NUM_WORDS = 64;
    localparam int DEF_IDX_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } rb_state_t;

endpackage

// File: rtl/param_readback_if.sv
// Pipe-out readback bundle: the packed parameter bus and control going in,
// the streamed word and status flags coming back.
interface param_readback_if
    import param_readback_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int IDX_W     = DEF_IDX_W
) ();

    logic                        start;
    logic [NUM_WORDS*WORD_W-1:0] packed_in;
    logic                        rd;
    logic [WORD_W-1:0]           dout;
    logic                        busy;
    logic                        done;
    logic [IDX_W-1:0]            word_idx;
    logic                        underrun;

    modport master (
        output start, packed_in, rd,
        input  dout, busy, done, word_idx, underrun
    );

    modport slave (
        input  start, packed_in, rd,
        output dout, busy, done, word_idx, underrun
    );

endinterface

// File: rtl/param_readback.sv
// Snapshots the packed parameter bus on start and streams it out one word
// per rd strobe, lowest word first, with a one-cycle done pulse at the end.
module param_readback
    import param_readback_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    param_readback_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    rb_state_t                             state;
    logic [NUM_WORDS-1:0][WORD_W-1:0]      snapshot;
    logic [IDX_W-1:0]                      idx_next;
    logic                                  load;

    assign load     = (state == ST_IDLE) && bus.start;
    assign idx_next = bus.word_idx + IDX_W'(1);

    // NOTE: the snapshot is pure data storage gated by load; it is left out of
    // reset on purpose so it maps to plain enabled flops with no reset fan-out.
    always_ff @(posedge clk) begin
        if (!reset && load) begin
            snapshot <= bus.packed_in;
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            bus.word_idx <= '0;
            bus.dout     <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // A simultaneous rd overrides the clear of underrun.
                        state        <= ST_STREAM;
                        bus.word_idx <= '0;
                        bus.dout     <= bus.packed_in[WORD_W-1:0];
                        bus.busy     <= 1'b1;
                        bus.underrun <= bus.rd;
                    end else if (bus.rd) begin
                        bus.underrun <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (bus.rd) begin
                        if (bus.word_idx == LAST_IDX) begin
                            state        <= ST_DONE;
                            bus.word_idx <= '0;
                            bus.dout     <= '0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                        end else begin
                            bus.word_idx <= idx_next;
                            bus.dout     <= snapshot[idx_next];
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (bus.rd) begin
                        bus.underrun <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_readback.sv
// Directed self-checking bench for param_readback: ramp streaming, snapshot
// isolation, underrun, read gaps, mid-stream reset and ignored restart.
module tb_param_readback;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 64;
    localparam int IDX_W     = 6;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    param_readback_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) bus ();

    param_readback #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change after the falling edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < NUM_WORDS; k++) begin
            bus.packed_in[k*WORD_W +: WORD_W] = WORD_W'(16'h1000 + k);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.rd        = 1'b0;
        bus.packed_in = '0;
        @(negedge clk);

        // Reset state
        bus.rd = 1'b1;
        do_reset();
        bus.rd = 1'b0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_idx", 32'(bus.word_idx), 0);
        check("rst_underrun", 32'(bus.underrun), 0);

        // Continuous rd: one word per cycle, done right after the 64th read
        fill_ramp();
        do_start();
        check("s1_busy", 32'(bus.busy), 1);
        bus.rd = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) begin
            check($sformatf("s1_dout%0d", i), 32'(bus.dout), 32'h1000 + i);
            check($sformatf("s1_idx%0d", i), 32'(bus.word_idx), i);
            check($sformatf("s1_done%0d", i), 32'(bus.done), 0);
            tick();
        end
        bus.rd = 1'b0;
        check("s1_done_pulse", 32'(bus.done), 1);
        check("s1_busy_fall", 32'(bus.busy), 0);
        check("s1_dout_done", 32'(bus.dout), 0);
        check("s1_idx_wrap", 32'(bus.word_idx), 0);
        check("s1_underrun", 32'(bus.underrun), 0);
        tick();
        check("s1_done_once", 32'(bus.done), 0);
        check("s1_idle_dout", 32'(bus.dout), 0);

        // Snapshot isolation, plus a start at word 20 that must be ignored
        fill_ramp();
        do_start();
        for (int k = 0; k < NUM_WORDS; k++) bus.packed_in[k*WORD_W +: WORD_W] = 16'hFFFF;
        bus.rd = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) begin
            check($sformatf("s2_dout%0d", i), 32'(bus.dout), 32'h1000 + i);
            check($sformatf("s2_idx%0d", i), 32'(bus.word_idx), i);
            bus.start = (i == 20);
            tick();
            bus.start = 1'b0;
        end
        bus.rd = 1'b0;
        check("s2_done_pulse", 32'(bus.done), 1);
        tick();

        // Underrun in IDLE, then cleared by a later start
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("s3_underrun_set", 32'(bus.underrun), 1);
        check("s3_dout", 32'(bus.dout), 0);
        check("s3_busy", 32'(bus.busy), 0);
        fill_ramp();
        do_start();
        check("s3_underrun_clr", 32'(bus.underrun), 0);
        check("s3_first", 32'(bus.dout), 32'h1000);

        // Read gaps of 3 idle cycles; dout/word_idx hold in the gaps
        for (int i = 0; i < NUM_WORDS; i++) begin
            for (int g = 0; g < 3; g++) begin
                check($sformatf("s4_hold_dout%0d", i), 32'(bus.dout), 32'h1000 + i);
                check($sformatf("s4_hold_idx%0d", i), 32'(bus.word_idx), i);
                tick();
            end
            check($sformatf("s4_nodone%0d", i), 32'(bus.done), 0);
            bus.rd = 1'b1;
            tick();
            bus.rd = 1'b0;
        end
        check("s4_done_pulse", 32'(bus.done), 1);
        check("s4_busy", 32'(bus.busy), 0);
        // rd during the DONE cycle is an underrun
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("s4_done_once", 32'(bus.done), 0);
        check("s4_underrun_done", 32'(bus.underrun), 1);
        check("s4_idle_busy", 32'(bus.busy), 0);

        // Reset after the 10th read aborts with no done pulse
        do_start();
        bus.rd = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.rd = 1'b0;
        check("s5_idx10", 32'(bus.word_idx), 10);
        check("s5_dout10", 32'(bus.dout), 32'h100A);
        do_reset();
        check("s5_busy", 32'(bus.busy), 0);
        check("s5_idx", 32'(bus.word_idx), 0);
        check("s5_dout", 32'(bus.dout), 0);
        check("s5_done", 32'(bus.done), 0);
        tick();
        check("s5_done_after", 32'(bus.done), 0);
        do_start();
        check("s5_restart_dout", 32'(bus.dout), 32'h1000);
        check("s5_restart_idx", 32'(bus.word_idx), 0);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check("s5_restart_next", 32'(bus.dout), 32'h1001);

        // start and rd together in IDLE: streams, but underrun is set
        do_reset();
        bus.start = 1'b1;
        bus.rd    = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.rd    = 1'b0;
        check("s6_busy", 32'(bus.busy), 1);
        check("s6_underrun", 32'(bus.underrun), 1);
        check("s6_dout", 32'(bus.dout), 32'h1000);
        check("s6_idx", 32'(bus.word_idx), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_readback.md
PARAM_READBACK -- requirements
Module: param_readback

Interface
REQ-001 Parameter WORD_W, default 16, width of one streamed word.
REQ-002 Parameter NUM_WORDS, default 64, number of words in the packed bus.
REQ-003 Parameter IDX_W, default 6, width of the word index (clog2 of NUM_WORDS).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to snapshot packed_in and begin streaming.
REQ-007 packed_in  input  NUM_WORDS*WORD_W  packed parameter bus; word k is bits [k*WORD_W +: WORD_W], matching the block-address order used to fill it.
REQ-008 rd  input  1  pipe-out read strobe; the word on dout is consumed in the cycle rd is high.
REQ-009 dout  output  WORD_W  current word presented to the pipe-out endpoint.
REQ-010 busy  output  1  high while in STREAM.
REQ-011 done  output  1  one-cycle pulse after the last word is consumed.
REQ-012 word_idx  output  IDX_W  index of the word currently on dout.
REQ-013 underrun  output  1  sticky flag: rd seen while not streaming.

Function
REQ-014 States SHALL be IDLE, STREAM and DONE, encoded as a registered state machine.
REQ-015 In IDLE with start=1, the block SHALL copy packed_in into an internal snapshot register, set word_idx=0, clear underrun, and enter STREAM on the next edge.
REQ-016 dout SHALL be a registered output equal to snapshot word word_idx, valid from the first cycle in STREAM (latency start->valid dout = 1 cycle).
REQ-017 In STREAM, rd=1 with word_idx<NUM_WORDS-1 SHALL increment word_idx and present the next word on dout in the following cycle.
REQ-018 In STREAM, rd=1 with word_idx=NUM_WORDS-1 SHALL enter DONE; word_idx SHALL wrap to 0.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 dout SHALL be 0 in IDLE and DONE.
REQ-021 start while in STREAM or DONE SHALL be ignored; the snapshot SHALL not change.
REQ-022 Changes on packed_in after the snapshot SHALL not affect dout.
REQ-023 rd in IDLE or DONE SHALL set underrun=1 and leave all other state unchanged.
REQ-024 start and rd both high in IDLE SHALL start streaming and set underrun=1; the start clear is overridden by the rd.
REQ-025 rd held high continuously SHALL stream one word per cycle with no bubbles.

Reset
REQ-026 reset=1 SHALL take priority over all inputs and force state=IDLE, word_idx=0, dout=0, busy=0, done=0, underrun=0 on the next edge.
REQ-027 reset asserted mid-STREAM SHALL abort the transfer with no done pulse; the snapshot contents are don't-care.

Structure
REQ-028 WORD_W, NUM_WORDS, IDX_W and the state encoding SHALL live in the shared wave-generator package used by the parameter-packing block.
REQ-029 The block SHALL be a single module; the 64:1 word select SHALL be inline, with no sub-module.

Verification
REQ-030 Load packed_in word k = 16'h1000+k, pulse start, then hold rd high for 64 cycles -> dout sequence 1000..103F, done pulses once in the cycle after the 64th rd, busy falls with it.
REQ-031 After start, change packed_in to all 16'hFFFF, then read 64 words -> dout still 1000..103F.
REQ-032 Pulse rd in IDLE -> underrun=1, dout=0; a later start -> underrun=0.
REQ-033 Stream with rd gaps of 3 idle cycles between reads -> dout and word_idx hold during the gaps; 64 words are output, then a single done pulse.
REQ-034 Assert reset after the 10th read -> next cycle busy=0, word_idx=0, dout=0, no done pulse; a new start restreams from word 0.
REQ-035 Pulse start again at word_idx=20 -> ignored; the stream continues at 21 with the original snapshot.
